crh_sequencer: RTL

Request sequencer directly upstream of the CRH region filter. It accepts increment requests (line fills), decrement requests (evictions) and probe requests (snoops) from the cache controller and buffers them. It drives the CRH's increment/decrement/probe strobes and addresses, held for the two cycles the CRH update needs, and returns the probe result. It guarantees the CRH never sees an increment and a decrement to the same region in one operation window, and never sees back-to-back operations without a settle cycle.

---
 rtl/crh_sequencer.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/crh_sequencer.sv
// Request sequencer in front of the CRH region filter: buffers fills/evicts/probes
// and issues them as two-cycle operation windows separated by a settle cycle.

module crh_sequencer_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head_c,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     room_next_c
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_d;

  assign head_c = mem[rd_ptr];

  always_comb begin
    count_d = count + CNT_W'(push) - CNT_W'(pop);
  end

  // Lets the owner register its ready flag against next-cycle occupancy.
  assign room_next_c = (count_d < CNT_W'(DEPTH));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= push_data;
  end
endmodule

module crh_sequencer #(
  parameter int unsigned REGION_WIDTH = 11,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        fill_valid,
  output logic        fill_ready,
  input  logic [31:0] fill_address,
  input  logic        evict_valid,
  output logic        evict_ready,
  input  logic [31:0] evict_address,
  input  logic        probe_valid,
  output logic        probe_ready,
  input  logic [31:0] probe_address,
  output logic        probe_done,
  output logic        probe_empty,
  output logic        increment,
  output logic        decrement,
  output logic        probe,
  output logic [31:0] increment_address,
  output logic [31:0] decrement_address,
  output logic [31:0] probe_address_out,
  input  logic        p
);
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {IDLE, ISSUE1, ISSUE2, GAP} state_t;

  state_t            state_q;
  state_t            state_d;
  logic [31:0]       inc_head;
  logic [31:0]       dec_head;
  logic [CNT_W-1:0]  inc_count;
  logic [CNT_W-1:0]  dec_count;
  logic              inc_room_next;
  logic              dec_room_next;
  logic              probe_pending;
  logic              pending_d;
  logic [31:0]       probe_addr_q;
  logic              fill_push;
  logic              evict_push;
  logic              probe_accept;
  logic              inc_pop;
  logic              dec_pop;
  logic              cancel;
  logic              issue;
  logic              load_inc;
  logic              load_dec;
  logic              load_probe;
  logic              probe_finish;
  logic              inc_valid;
  logic              dec_valid;
  logic              same_region;

  assign fill_push    = fill_valid  && fill_ready;
  assign evict_push   = evict_valid && evict_ready;
  assign probe_accept = probe_valid && probe_ready;
  assign inc_valid    = (inc_count != '0);
  assign dec_valid    = (dec_count != '0);
  assign same_region  = (inc_head[31 -: REGION_WIDTH] == dec_head[31 -: REGION_WIDTH]);

  crh_sequencer_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_inc_fifo (
    .clock       (clock),
    .reset_n     (reset_n),
    .push        (fill_push),
    .push_data   (fill_address),
    .pop         (inc_pop),
    .head_c      (inc_head),
    .count       (inc_count),
    .room_next_c (inc_room_next)
  );

  crh_sequencer_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(32)) u_dec_fifo (
    .clock       (clock),
    .reset_n     (reset_n),
    .push        (evict_push),
    .push_data   (evict_address),
    .pop         (dec_pop),
    .head_c      (dec_head),
    .count       (dec_count),
    .room_next_c (dec_room_next)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Operation selection: cancel, paired inc/dec, single head, then probe once drained.
  always_comb begin
    state_d    = state_q;
    cancel     = 1'b0;
    load_inc   = 1'b0;
    load_dec   = 1'b0;
    load_probe = 1'b0;
    case (state_q)
      IDLE: begin
        if (inc_valid && dec_valid && same_region) begin
          cancel = 1'b1;
        end else if (inc_valid || dec_valid) begin
          load_inc = inc_valid;
          load_dec = dec_valid;
          state_d  = ISSUE1;
        end else if (probe_pending) begin
          load_probe = 1'b1;
          state_d    = ISSUE1;
        end
      end
      ISSUE1:  state_d = ISSUE2;
      ISSUE2:  state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    issue        = load_inc || load_dec || load_probe;
    inc_pop      = cancel || ((state_q == ISSUE2) && increment);
    dec_pop      = cancel || ((state_q == ISSUE2) && decrement);
    probe_finish = (state_q == ISSUE2) && probe;
    pending_d    = probe_accept || (probe_pending && !probe_finish);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      probe_pending <= 1'b0;
      probe_addr_q  <= '0;
      fill_ready    <= 1'b1;
      evict_ready   <= 1'b1;
      probe_ready   <= 1'b1;
    end else begin
      probe_pending <= pending_d;
      if (probe_accept) probe_addr_q <= probe_address;
      fill_ready    <= inc_room_next && !pending_d;
      evict_ready   <= dec_room_next && !pending_d;
      probe_ready   <= !pending_d;
    end
  end

  // CRH strobes held through ISSUE1/ISSUE2, zero otherwise.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      increment         <= 1'b0;
      decrement         <= 1'b0;
      probe             <= 1'b0;
      increment_address <= '0;
      decrement_address <= '0;
      probe_address_out <= '0;
      probe_done        <= 1'b0;
      probe_empty       <= 1'b0;
    end else begin
      probe_done  <= probe_finish;
      probe_empty <= probe_finish && p;
      if (issue) begin
        increment         <= load_inc;
        decrement         <= load_dec;
        probe             <= load_probe;
        increment_address <= load_inc   ? inc_head     : '0;
        decrement_address <= load_dec   ? dec_head     : '0;
        probe_address_out <= load_probe ? probe_addr_q : '0;
      end else if (state_q == ISSUE2) begin
        increment         <= 1'b0;
        decrement         <= 1'b0;
        probe             <= 1'b0;
        increment_address <= '0;
        decrement_address <= '0;
        probe_address_out <= '0;
      end
    end
  end
endmodule
